// File: rtl/mdr_mem_unit_pkg.sv
// mdr_mem_unit_pkg
//   Shared definitions for the MAR/MDR memory-interface stage and the
//   datapath blocks around it (bus mux, registers).
//   - DATA_W_DEF / ADDR_W_DEF : default bus and memory address widths
//   - TIMEOUT_DEF             : default ack wait bound, in cycles
//   - state_t                 : memory-transaction FSM encoding
//   - isWaitState()           : true while a request is outstanding
package mdr_mem_unit_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int ADDR_W_DEF  = 9;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    WR_WAIT = 3'd2,
    DONE    = 3'd3,
    ABORT   = 3'd4
  } state_t;

  function automatic logic isWaitState(input state_t s);
    return (s == RD_WAIT) || (s == WR_WAIT);
  endfunction

endpackage

// File: rtl/mdr_mem_unit_timer.sv
// mem_wait_timer
//   Counts cycles spent waiting for a memory acknowledge.
//   clk      : rising-edge clock
//   clr_n    : asynchronous active-low reset
//   clear    : synchronous clear (dominates enable)
//   enable   : advance the count by one this cycle
//   terminal : count has reached TIMEOUT-1, i.e. this is the last wait cycle
module mem_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic clr_n,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  logic [7:0] count;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  // The FSM leaves the wait state on terminal, so the count never wraps.
  assign terminal = (count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mdr_mem_unit.sv
// mdr_mem_unit
//   MAR/MDR memory-interface stage feeding the datapath bus mux. Loads MAR
//   and MDR from BusMuxOut, runs one req/ack memory transaction per Read or
//   Write strobe, and aborts with a timeout pulse if ack never arrives.
//   clk, clr_n            : clock, asynchronous active-low reset
//   BusMuxOut             : datapath bus, source for MAR/MDR loads
//   MARin, MDRin          : register load strobes (honoured in IDLE only)
//   Read, Write           : transaction start strobes (Read wins a tie)
//   mem_rdata, mem_ack    : memory read data and one-cycle acknowledge
//   mem_req, mem_we       : request (held until ack/abort), write select
//   mem_addr, mem_wdata   : MAR and MDR contents
//   BusMuxInMDR           : MDR contents toward the bus mux
//   busy, done, timeout   : in-flight flag, completion and abort pulses
module mdr_mem_unit
  import mdr_mem_unit_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [DATA_W-1:0] BusMuxOut,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              Read,
  input  logic              Write,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] BusMuxInMDR,
  output logic              busy,
  output logic              done,
  output logic              timeout
);

  state_t            state;
  state_t            nextState;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mdr;
  logic              inWait;
  logic              waitTerminal;

  assign inWait = isWaitState(state);

  // Clearing outside the wait states means the count starts at 0 on entry.
  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .clr_n    (clr_n),
    .clear    (!inWait),
    .enable   (inWait && !mem_ack),
    .terminal (waitTerminal)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // NOTE: nextState gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (Read) begin
          nextState = RD_WAIT;
        end else if (Write) begin
          nextState = WR_WAIT;
        end
      end
      RD_WAIT, WR_WAIT: begin
        // Ack on the final count still completes the transaction.
        if (mem_ack) begin
          nextState = DONE;
        end else if (waitTerminal) begin
          nextState = ABORT;
        end
      end
      DONE, ABORT: nextState = IDLE;
      default:     nextState = IDLE;
    endcase
  end

  // MAR/MDR are two plain registers, cheap to reset, so they start from a
  // known zero like the rest of the state.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      mar <= '0;
      mdr <= '0;
    end else begin
      if (state == IDLE && MARin) begin
        mar <= BusMuxOut[ADDR_W-1:0];
      end
      if (state == IDLE && MDRin) begin
        mdr <= BusMuxOut;
      end else if (state == RD_WAIT && mem_ack) begin
        mdr <= mem_rdata;
      end
    end
  end

  // Moore outputs: decoded from the registered state only.
  assign mem_req     = inWait;
  assign busy        = inWait;
  assign mem_we      = (state == WR_WAIT);
  assign done        = (state == DONE);
  assign timeout     = (state == ABORT);
  assign mem_addr    = mar;
  assign mem_wdata   = mdr;
  assign BusMuxInMDR = mdr;

endmodule

// File: tb/tb_mdr_mem_unit.sv
module tb_mdr_mem_unit;

  localparam int DW = 32;
  localparam int AW = 9;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          clr_n;
  logic [DW-1:0] BusMuxOut;
  logic          MARin, MDRin, Read, Write;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, BusMuxInMDR;
  logic          busy, done, timeout;

  mdr_mem_unit #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .clr_n       (clr_n),
    .BusMuxOut   (BusMuxOut),
    .MARin       (MARin),
    .MDRin       (MDRin),
    .Read        (Read),
    .Write       (Write),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .BusMuxInMDR (BusMuxInMDR),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          isTimeout;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] mdr;
    int            waits;
  } exp_t;

  exp_t          expQ[$];
  int            nTests = 0;
  int            nFail  = 0;
  int            nDone  = 0;
  int            nTimeout = 0;
  logic [AW-1:0] marModel = '0;
  logic [DW-1:0] mdrModel = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: observes request cycles and pops one expectation per completion.
  int            waitCnt = 0;
  logic          weSeen;
  logic [AW-1:0] addrSeen;
  logic [DW-1:0] wdataSeen;

  always @(negedge clk) begin
    if (!clr_n) begin
      waitCnt = 0;
    end else begin
      if (mem_req) begin
        if (waitCnt == 0) begin
          weSeen    = mem_we;
          addrSeen  = mem_addr;
          wdataSeen = mem_wdata;
        end
        waitCnt++;
      end
      if (done) nDone++;
      if (timeout) nTimeout++;
      if (done || timeout) begin
        if (expQ.size() == 0) begin
          check("unexpected_completion", 64'(done), 64'(0));
        end else begin
          exp_t e;
          e = expQ.pop_front();
          check("timeout_flag", 64'(timeout), 64'(e.isTimeout));
          check("done_flag",    64'(done),    64'(!e.isTimeout));
          check("mem_we",       64'(weSeen),  64'(e.we));
          check("req_addr",     64'(addrSeen), 64'(e.addr));
          check("req_wdata",    64'(wdataSeen), 64'(e.wdata));
          check("end_addr",     64'(mem_addr), 64'(e.addr));
          check("mdr_out",      64'(BusMuxInMDR), 64'(e.mdr));
          check("wait_cycles",  64'(waitCnt), 64'(e.waits));
        end
        waitCnt = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic m, input logic d, input logic [DW-1:0] v);
    BusMuxOut = v;
    MARin = m;
    MDRin = d;
    step();
    MARin = 1'b0;
    MDRin = 1'b0;
    if (m) marModel = v[AW-1:0];
    if (d) mdrModel = v;
  endtask

  // ackAt: wait cycle (1-based) carrying mem_ack, 0 = never.
  // poke: drive MARin/MDRin/Read/Write with a new bus value on wait cycle 1.
  task automatic runTxn(input logic rd, input logic wr, input int ackAt,
                        input logic [DW-1:0] rdata, input logic loadMar, input logic poke);
    exp_t e;
    logic acked;
    acked = (ackAt >= 1) && (ackAt <= TO);
    if (loadMar) marModel = BusMuxOut[AW-1:0];
    e.isTimeout = !acked;
    e.we        = !rd && wr;
    e.addr      = marModel;
    e.wdata     = mdrModel;
    if (acked && rd) mdrModel = rdata;
    e.mdr       = mdrModel;
    e.waits     = acked ? ackAt : TO;
    expQ.push_back(e);

    Read = rd;
    Write = wr;
    MARin = loadMar;
    step();
    Read = 1'b0;
    Write = 1'b0;
    MARin = 1'b0;
    for (int c = 1; c <= TO; c++) begin
      if (poke && c == 1) begin
        BusMuxOut = 32'h0000_00AA;
        MARin = 1'b1;
        MDRin = 1'b1;
        Read = 1'b1;
        Write = 1'b1;
      end
      if (c == ackAt) begin
        mem_ack = 1'b1;
        mem_rdata = rdata;
      end
      step();
      MARin = 1'b0;
      MDRin = 1'b0;
      Read = 1'b0;
      Write = 1'b0;
      mem_ack = 1'b0;
      if (c == ackAt) break;
    end
    step();
    check("idle_busy", 64'(busy), 64'(0));
    check("idle_mdr",  64'(BusMuxInMDR), 64'(mdrModel));
    check("idle_mar",  64'(mem_addr), 64'(marModel));
  endtask

  initial begin
    clr_n = 1'b0;
    BusMuxOut = '0;
    MARin = 1'b0;
    MDRin = 1'b0;
    Read = 1'b0;
    Write = 1'b0;
    mem_rdata = '0;
    mem_ack = 1'b0;
    step();
    check("rst_req",  64'(mem_req), 64'(0));
    check("rst_mdr",  64'(BusMuxInMDR), 64'(0));
    check("rst_addr", 64'(mem_addr), 64'(0));
    clr_n = 1'b1;
    step();

    // Reset in the middle of a read drops mem_req without waiting for a clock.
    load(1'b1, 1'b1, 32'h0000_0123);
    Read = 1'b1;
    step();
    Read = 1'b0;
    step();
    check("pre_rst_req", 64'(mem_req), 64'(1));
    clr_n = 1'b0;
    #1;
    check("mid_rst_req",   64'(mem_req), 64'(0));
    check("mid_rst_busy",  64'(busy), 64'(0));
    check("mid_rst_we",    64'(mem_we), 64'(0));
    check("mid_rst_flags", 64'({done, timeout}), 64'(0));
    check("mid_rst_addr",  64'(mem_addr), 64'(0));
    check("mid_rst_mdr",   64'(BusMuxInMDR), 64'(0));
    check("mid_rst_wdata", 64'(mem_wdata), 64'(0));
    marModel = '0;
    mdrModel = '0;
    step();
    clr_n = 1'b1;
    step();

    // Read, ack on the second wait cycle.
    load(1'b1, 1'b0, 32'h0000_0123);
    runTxn(1'b1, 1'b0, 2, 32'hDEAD_BEEF, 1'b0, 1'b0);
    check("read_done_count", 64'(nDone), 64'(1));

    // Write with immediate ack; rdata must not reach MDR.
    load(1'b0, 1'b1, 32'hA5A5_A5A5);
    load(1'b1, 1'b0, 32'h0000_01FF);
    runTxn(1'b0, 1'b1, 1, 32'h1234_5678, 1'b0, 1'b0);

    // No ack: abort after exactly TO wait cycles, MDR kept.
    runTxn(1'b1, 1'b0, 0, 32'h0BAD_0BAD, 1'b0, 1'b0);
    check("timeout_count", 64'(nTimeout), 64'(1));

    // Ack on the last permitted cycle completes instead of aborting.
    runTxn(1'b1, 1'b0, TO, 32'h0BAD_F00D, 1'b0, 1'b0);

    // Read and Write together: read only.
    runTxn(1'b1, 1'b1, 1, 32'hCAFE_F00D, 1'b0, 1'b0);

    // Loads and strobes while busy are ignored.
    BusMuxOut = 32'h0000_0055;
    runTxn(1'b1, 1'b0, 3, 32'h1357_9BDF, 1'b0, 1'b1);

    // MARin together with Write: transaction uses the new address.
    BusMuxOut = 32'h0000_0099;
    runTxn(1'b0, 1'b1, 2, 32'h0, 1'b1, 1'b0);

    // Stray ack in IDLE has no effect.
    mem_ack = 1'b1;
    mem_rdata = 32'hFFFF_0000;
    step();
    step();
    mem_ack = 1'b0;
    check("stray_ack_mdr",  64'(BusMuxInMDR), 64'(mdrModel));
    check("stray_ack_req",  64'(mem_req), 64'(0));

    step();
    step();
    check("queue_empty",  64'(expQ.size()), 64'(0));
    check("total_done",   64'(nDone), 64'(6));
    check("total_timeout", 64'(nTimeout), 64'(1));
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
